// File: rtl/barrel_shift_arbiter.sv
// Two-port round-robin front end for one shared 32-bit log rotator.
// Optional BARREL_ARITH_EN enables true arithmetic shift right for op 10.
module barrel_shift_arbiter #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_num,
  input  logic [AW-1:0] req0_amt,
  input  logic          req0_lr,
  input  logic [1:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_num,
  input  logic [AW-1:0] req1_amt,
  input  logic          req1_lr,
  input  logic [1:0]    req1_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_id,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ROT = 2'b00;
  localparam logic [1:0] OP_LSH = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_PAS = 2'b11;

  state_t        state, state_nx;
  logic          last_grant;
  logic          gnt_valid;
  logic          gnt_id;
  logic [W-1:0]  op_num;
  logic [AW-1:0] op_amt;
  logic          op_lr;
  logic [1:0]    op_op;
  logic          op_id;
  logic          dir;
  logic [W-1:0]  rot;
  logic [W-1:0]  mask;
  logic [W-1:0]  res;

  function automatic logic [W-1:0] rol(
    input logic [W-1:0] x,
    input int           s
  );
    return (x << s) | (x >> (W - s));
  endfunction

  function automatic logic [W-1:0] ror(
    input logic [W-1:0] x,
    input int           s
  );
    return (x >> s) | (x << (W - s));
  endfunction

  // Both requesters valid: the one not served last wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        (req0_valid && req1_valid): begin
          gnt_valid = 1'b1;
          gnt_id    = ~last_grant;
        end
        (req0_valid && !req1_valid): begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b0;
        end
        (!req0_valid && req1_valid): begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b1;
        end
        default: begin
          gnt_valid = 1'b0;
          gnt_id    = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = gnt_valid && !gnt_id;
  assign req1_ready = gnt_valid && gnt_id;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_valid) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_num     <= '0;
      op_amt     <= '0;
      op_lr      <= 1'b0;
      op_op      <= OP_ROT;
      op_id      <= 1'b0;
    end else if (gnt_valid) begin
      last_grant <= gnt_id;
      op_id      <= gnt_id;
      op_num     <= gnt_id ? req1_num : req0_num;
      op_amt     <= gnt_id ? req1_amt : req0_amt;
      op_lr      <= gnt_id ? req1_lr  : req0_lr;
      op_op      <= gnt_id ? req1_op  : req0_op;
    end
  end

  // Arith op always shifts right.
  assign dir = (op_op == OP_ASR) ? 1'b0 : op_lr;

  always_comb begin
    rot = op_num;
    for (int i = 0; i < AW; i++) begin
      if (op_amt[i]) rot = dir ? rol(rot, 1 << i) : ror(rot, 1 << i);
    end
  end

  assign mask = dir ? ({W{1'b1}} << op_amt) : ({W{1'b1}} >> op_amt);

  always_comb begin
    res = rot;
    unique case (op_op)
      OP_ROT: res = rot;
      OP_LSH: res = rot & mask;
`ifdef BARREL_ARITH_EN
      OP_ASR: res = (rot & mask) | ({W{op_num[W-1]}} & ~mask);
`else
      OP_ASR: res = rot & mask;
`endif
      OP_PAS: res = op_num;
      default: res = rot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= res;
      rsp_id    <= op_id;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
